// File: rtl/bcd_arb_pkg.sv
// Shared constants and FSM encoding for the round-robin BCD conversion arbiter.
package bcd_arb_pkg;
  localparam int BIN_W      = 20;
  localparam int BCD_DIGITS = 6;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int BCD_MAX    = 999999;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/bcd_dabble_core.sv
// Double-dabble binary-to-BCD core: one add-3/shift step per cycle, done pulses on the last step.
// A start pulse reloads the shift register; no backpressure, the result holds until the next start.
module bcd_dabble_core #(
  parameter int BIN_W = 20
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             done,
  output logic [23:0]      bcd
);
  import bcd_arb_pkg::*;

  localparam int CW = $clog2(BIN_W + 1);

  logic [BCD_W+BIN_W-1:0] sr;
  logic [BCD_W+BIN_W-1:0] adj;
  logic [CW-1:0]          cnt;
  logic                   run;

  always_comb begin
    adj = sr;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (adj[BIN_W+4*d +: 4] > 4'd4)
        adj[BIN_W+4*d +: 4] = adj[BIN_W+4*d +: 4] + 4'd3;
    end
  end

  assign done = run && (cnt == CW'(BIN_W - 1));
  assign bcd  = sr[BIN_W +: BCD_W];

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sr  <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      sr  <= {{BCD_W{1'b0}}, bin};
      cnt <= '0;
      run <= 1'b1;
    end else if (run) begin
      sr  <= {adj[BCD_W+BIN_W-2:0], 1'b0};
      cnt <= cnt + CW'(1);
      if (done)
        run <= 1'b0;
    end
  end
endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter feeding a shared double-dabble converter; result valid BIN_W+1 cycles after ack.
// Requests are level-held until ack and only sampled while idle, one grant per BIN_W+2 cycles.
module bcd_conv_arbiter #(
  parameter int N_REQ = 3,
  parameter int BIN_W = 20
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*BIN_W-1:0] data_in,
  output logic [N_REQ-1:0]       ack,
  output logic [23:0]            bcd_data,
  output logic                   bcd_valid,
  output logic [1:0]             bcd_src,
  output logic                   bcd_ovf,
  output logic                   busy
);
  import bcd_arb_pkg::*;

  state_t           state, state_nxt;
  logic [1:0]       last_grant;
  logic [1:0]       winner;
  logic             grant;
  logic             ovf_q;
  logic             ovf_calc;
  logic [BIN_W-1:0] bin_sel;
  logic [N_REQ-1:0] ack_nxt;
  logic             core_done;
  logic [23:0]      core_bcd;

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    int  idx;
    logic found;
    winner = last_grant;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_grant) + k) % N_REQ;
      if (!found && req[idx]) begin
        winner = 2'(idx);
        found  = 1'b1;
      end
    end
  end

  assign grant    = (state == IDLE) && (|req);
  assign bin_sel  = data_in[int'(winner)*BIN_W +: BIN_W];
  assign ovf_calc = 32'(bin_sel) >= 32'(BCD_MAX + 1);
  assign busy     = (state != IDLE);

  always_comb begin
    ack_nxt = '0;
    if (grant)
      ack_nxt[winner] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = CONV;
      CONV:    if (core_done) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      last_grant <= 2'(N_REQ - 1);
      ovf_q      <= 1'b0;
      ack        <= '0;
      bcd_valid  <= 1'b0;
      bcd_data   <= '0;
      bcd_src    <= '0;
      bcd_ovf    <= 1'b0;
    end else begin
      ack       <= ack_nxt;
      bcd_valid <= (state == DONE);
      if (grant) begin
        last_grant <= winner;
        ovf_q      <= ovf_calc;
      end
      if (state == DONE) begin
        bcd_data <= ovf_q ? 24'h999999 : core_bcd;
        bcd_src  <= last_grant;
        bcd_ovf  <= ovf_q;
      end
    end
  end

  bcd_dabble_core #(.BIN_W(BIN_W)) u_core (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .start   (grant),
    .bin     (bin_sel),
    .done    (core_done),
    .bcd     (core_bcd)
  );
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter with a timer-based reference model checked every cycle.
module tb_bcd_conv_arbiter;
  localparam int N_REQ = 3;
  localparam int BIN_W = 20;

  logic                   sys_clk = 1'b0;
  logic                   sys_rst;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*BIN_W-1:0] data_in;
  logic [N_REQ-1:0]       ack;
  logic [23:0]            bcd_data;
  logic                   bcd_valid;
  logic [1:0]             bcd_src;
  logic                   bcd_ovf;
  logic                   busy;

  bcd_conv_arbiter #(.N_REQ(N_REQ), .BIN_W(BIN_W)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .req       (req),
    .data_in   (data_in),
    .ack       (ack),
    .bcd_data  (bcd_data),
    .bcd_valid (bcd_valid),
    .bcd_src   (bcd_src),
    .bcd_ovf   (bcd_ovf),
    .busy      (busy)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge sys_clk) cyc++;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic timeout(string name);
    n_checks++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
  endtask

  function automatic logic [23:0] to_bcd(int v);
    logic [23:0] r;
    r = '0;
    if (v >= 1000000) return 24'h999999;
    for (int d = 0; d < 6; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Reference: a grant occupies the converter for BIN_W+1 cycles, the result lands on the last one.
  int          m_last, m_timer;
  logic [2:0]  m_ack;
  logic        m_valid, m_busy, m_ovf, p_ovf;
  logic [23:0] m_data, p_data;
  logic [1:0]  m_src, p_src;

  always @(posedge sys_clk or posedge sys_rst) begin
    int w, v;
    bit found;
    if (sys_rst) begin
      m_last = N_REQ - 1; m_timer = 0; m_ack = '0; m_valid = 1'b0; m_busy = 1'b0;
      m_data = '0; m_src = '0; m_ovf = 1'b0;
    end else begin
      m_ack = '0;
      m_valid = 1'b0;
      if (m_timer == 0) begin
        if (req != 0) begin
          found = 0;
          w = 0;
          for (int k = 1; k <= N_REQ; k++) begin
            if (!found && req[(m_last + k) % N_REQ]) begin
              w = (m_last + k) % N_REQ;
              found = 1;
            end
          end
          v = int'(data_in[w*BIN_W +: BIN_W]);
          m_ack[w] = 1'b1;
          m_last   = w;
          p_data   = to_bcd(v);
          p_ovf    = (v >= 1000000);
          p_src    = 2'(w);
          m_timer  = BIN_W + 1;
        end
      end else begin
        m_timer--;
        if (m_timer == 0) begin
          m_valid = 1'b1;
          m_data  = p_data;
          m_src   = p_src;
          m_ovf   = p_ovf;
        end
      end
      m_busy = (m_timer != 0);
    end
  end

  always @(posedge sys_clk) begin
    #1;
    check("cmp_ack",   32'(ack),       32'(m_ack));
    check("cmp_valid", 32'(bcd_valid), 32'(m_valid));
    check("cmp_data",  32'(bcd_data),  32'(m_data));
    check("cmp_src",   32'(bcd_src),   32'(m_src));
    check("cmp_ovf",   32'(bcd_ovf),   32'(m_ovf));
    check("cmp_busy",  32'(busy),      32'(m_busy));
  end

  logic [25:0] vq[$];
  always @(negedge sys_clk) if (bcd_valid) vq.push_back({bcd_src, bcd_data});

  task automatic wait_ack(string nm, output logic [2:0] a, output int c);
    a = '0;
    c = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge sys_clk);
      if (ack != 0) begin
        a = ack;
        c = cyc;
        return;
      end
    end
    timeout(nm);
  endtask

  task automatic wait_valid(string nm, output int lat);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge sys_clk);
      lat++;
      if (bcd_valid) return;
    end
    timeout(nm);
    lat = -1;
  endtask

  task automatic check_zero_outputs(string nm);
    check({nm, "_ack"},   32'(ack),       0);
    check({nm, "_valid"}, 32'(bcd_valid), 0);
    check({nm, "_data"},  32'(bcd_data),  0);
    check({nm, "_src"},   32'(bcd_src),   0);
    check({nm, "_ovf"},   32'(bcd_ovf),   0);
    check({nm, "_busy"},  32'(busy),      0);
  endtask

  task automatic single(string nm, logic [2:0] r, int idx, int val,
                        logic [23:0] exp_d, logic [1:0] exp_s, logic exp_o, int chg);
    logic [2:0] a;
    int c, lat;
    @(negedge sys_clk);
    data_in[idx*BIN_W +: BIN_W] = 20'(val);
    req = r;
    wait_ack({nm, "_ackwait"}, a, c);
    check({nm, "_ack"}, 32'(a), 32'(r));
    req = '0;
    if (chg >= 0) begin
      @(negedge sys_clk);
      data_in[idx*BIN_W +: BIN_W] = 20'(chg);
    end
    wait_valid({nm, "_validwait"}, lat);
    if (chg >= 0 && lat >= 0) lat++;
    check({nm, "_latency"}, 32'(lat), 21);
    check({nm, "_data"}, 32'(bcd_data), 32'(exp_d));
    check({nm, "_src"},  32'(bcd_src),  32'(exp_s));
    check({nm, "_ovf"},  32'(bcd_ovf),  32'(exp_o));
    @(negedge sys_clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] a;
    logic [2:0] exp_acks[4];
    int c[4];
    int lat, nvalid;

    exp_acks = '{3'b001, 3'b010, 3'b100, 3'b001};
    sys_rst = 1'b1;
    req     = '0;
    data_in = '0;
    repeat (3) @(negedge sys_clk);
    check_zero_outputs("reset");
    sys_rst = 1'b0;

    // All three requesting: grants rotate 0,1,2,0 at the converter's throughput.
    @(negedge sys_clk);
    vq.delete();
    data_in = {20'd33, 20'd22, 20'd11};
    req = 3'b111;
    for (int g = 0; g < 4; g++) begin
      wait_ack("rr_ackwait", a, c[g]);
      check("rr_ack", 32'(a), 32'(exp_acks[g]));
      if (g > 0) check("rr_spacing", 32'(c[g] - c[g-1]), 22);
    end
    req = '0;
    wait_valid("rr_validwait", lat);
    repeat (3) @(negedge sys_clk);
    check("rr_count", 32'(vq.size()), 4);
    if (vq.size() >= 3) begin
      check("rr_res0", 32'(vq[0]), 32'({2'd0, 24'h000011}));
      check("rr_res1", 32'(vq[1]), 32'({2'd1, 24'h000022}));
      check("rr_res2", 32'(vq[2]), 32'({2'd2, 24'h000033}));
    end

    single("t_123456", 3'b001, 0, 123456,  24'h123456, 2'd0, 1'b0, -1);
    single("t_zero",   3'b010, 1, 0,       24'h000000, 2'd1, 1'b0, -1);
    single("t_999999", 3'b100, 2, 999999,  24'h999999, 2'd2, 1'b0, -1);
    single("t_sat",    3'b001, 0, 1048575, 24'h999999, 2'd0, 1'b1, -1);
    single("t_hold",   3'b001, 0, 777,     24'h000777, 2'd0, 1'b0, 5);

    // Abort a conversion mid-flight with reset.
    @(negedge sys_clk);
    data_in[0 +: BIN_W] = 20'd4242;
    req = 3'b001;
    wait_ack("abort_ackwait", a, c[0]);
    check("abort_ack", 32'(a), 32'(3'b001));
    req = '0;
    repeat (10) @(negedge sys_clk);
    sys_rst = 1'b1;
    #1;
    check_zero_outputs("abort");
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge sys_clk);
      if (bcd_valid) nvalid++;
    end
    check("abort_no_valid", 32'(nvalid), 0);

    data_in = {20'd2, 20'd1, 20'd0};
    req = 3'b110;
    wait_ack("post_rst_ackwait", a, c[0]);
    check("post_rst_ack", 32'(a), 32'(3'b010));
    req = '0;
    wait_valid("post_rst_validwait", lat);
    check("post_rst_data", 32'(bcd_data), 32'(24'h000001));
    check("post_rst_src",  32'(bcd_src),  1);

    repeat (3) @(negedge sys_clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/bcd_conv_arbiter.md
BCD_CONV_ARBITER -- requirements
Module: bcd_conv_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 3: number of requesters.
REQ-002 SHALL have parameter BIN_W, default 20: binary input width.
REQ-003 SHALL have port sys_clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port sys_rst, input, 1: reset, asynchronous, active-high (one clock; async active-high reset, fixed).
REQ-005 SHALL have port req, input, N_REQ: level request per requester; held until its ack.
REQ-006 SHALL have port data_in, input, N_REQ*BIN_W: requester i value at bits [i*BIN_W +: BIN_W].
REQ-007 SHALL have port ack, output, N_REQ: one-cycle pulse to the requester whose data was latched.
REQ-008 SHALL have port bcd_data, output, 24: six packed BCD digits, hundred-thousands in [23:20], units in [3:0].
REQ-009 SHALL have port bcd_valid, output, 1: one-cycle pulse when bcd_data/bcd_src/bcd_ovf update.
REQ-010 SHALL have port bcd_src, output, 2: index of the requester that owns the current bcd_data.
REQ-011 SHALL have port bcd_ovf, output, 1: last result saturated.
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, CONV and DONE.
REQ-014 IDLE with req==0 SHALL stay IDLE with no outputs changing.
REQ-015 IDLE with any req bit set SHALL, at the next edge:
- choose the winner round-robin, starting after last_grant;
- latch the winner's data;
- pulse ack[winner];
- set last_grant to the winner;
- clear the shift counter;
- go to CONV.
REQ-016 Round-robin SHALL resolve as follows:
- last_grant resets to N_REQ-1, so req[0] has first priority;
- with all req bits held high, grants SHALL go 0,1,2,0,...
REQ-017 CONV SHALL perform one double-dabble step per cycle: add 3 to each BCD nibble greater than 4, then shift left 1, for exactly BIN_W cycles, then go to DONE.
REQ-018 DONE SHALL, at the next edge:
- register bcd_data, bcd_src and bcd_ovf;
- pulse bcd_valid for one cycle;
- return to IDLE.
REQ-019 Latency: bcd_valid SHALL be high in the cycle starting BIN_W+1 edges after the edge that raised ack (21 for BIN_W=20).
REQ-020 Throughput: the minimum spacing between grants SHALL be BIN_W+2 cycles (22).
REQ-021 req SHALL be sampled only in IDLE.
- Changes to req during CONV/DONE SHALL be ignored.
- A req withdrawn before it is granted SHALL NOT be served.
REQ-022 data_in SHALL be sampled only on the grant edge; later changes SHALL NOT affect the running conversion.
REQ-023 A latched value of 1_000_000 or more SHALL produce bcd_data=24'h999999 and bcd_ovf=1; otherwise bcd_ovf=0.
REQ-024 bcd_data, bcd_src and bcd_ovf SHALL hold their values between bcd_valid pulses.
REQ-025 At most one ack bit SHALL be high in any cycle.
REQ-026 A new grant SHALL NOT occur in the same cycle as bcd_valid.

Reset
REQ-027 sys_rst SHALL asynchronously force the following, and hold them while asserted:
- state=IDLE;
- ack=0, bcd_valid=0, busy=0;
- bcd_data=0, bcd_src=0, bcd_ovf=0;
- last_grant=N_REQ-1;
- shift counter and shift register = 0.
REQ-028 Reset during CONV or DONE SHALL abort the conversion, with no bcd_valid and no further ack for it.

Structure
REQ-029 Package bcd_arb_pkg SHALL hold BIN_W, BCD_DIGITS=6, BCD_MAX=999999 and the FSM state enum.
REQ-030 The double-dabble datapath SHALL be the sub-module bcd_dabble_core (start, bin, done, bcd); arbitration and the FSM SHALL stay in bcd_conv_arbiter.

Verification
REQ-031 req=3'b001, data0=123456 -> ack=3'b001 for one cycle; 21 cycles later bcd_valid=1, bcd_data=24'h123456, bcd_src=0, bcd_ovf=0.
REQ-032 Data extremes:
- data1=0 -> bcd_data=24'h000000, bcd_src=1;
- data2=999999 -> bcd_data=24'h999999, bcd_ovf=0.
REQ-033 data0=1048575 -> bcd_data=24'h999999, bcd_ovf=1.
REQ-034 req=3'b111 held, data 11/22/33 -> acks 0,1,2,0 spaced 22 cycles; outputs 24'h000011, 24'h000022, 24'h000033 with bcd_src 0,1,2.
REQ-035 Assert sys_rst 10 cycles into CONV -> all outputs immediately 0, no bcd_valid. After release, req=3'b110 -> req[1] is granted first.
REQ-036 Change data0 to 5 one cycle after ack while the conversion runs -> the result still reflects the latched value.
